// File: rtl/score_collect.sv
// score_collect: gathers one rate/distortion score per mode for a macroblock
// decision. Beats must arrive in mode order 0..NUM_MODES-1. Out-of-order beats
// are dropped with a one-cycle err_order pulse. The full set is then held
// until the best-mode selector takes it.
module score_collect #(
  parameter int NUM_MODES   = 10,
  parameter int DISTO_SHIFT = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_mode,
  input  logic [31:0] in_disto,
  input  logic [31:0] in_rate,
  input  logic [15:0] lambda,
  output logic [63:0] score0,
  output logic [63:0] score1,
  output logic [63:0] score2,
  output logic [63:0] score3,
  output logic [63:0] score4,
  output logic [63:0] score5,
  output logic [63:0] score6,
  output logic [63:0] score7,
  output logic [63:0] score8,
  output logic [63:0] score9,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_order
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [0:0]                  state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [15:0]                 lambda_q, lambda_d;
  logic                        err_order_q, err_order_d;
  logic [NUM_MODES-1:0][63:0]  score_q, score_d;

  logic        accept;
  logic        in_order;
  logic [15:0] lambda_sel;
  logic [47:0] prod;
  logic [63:0] disto_ext;
  logic [63:0] score_new;

  // Held in reset and during abort so the producer never sees a false accept.
  assign in_ready  = (state_q == COLLECT) && !abort && rstn;
  assign accept    = in_valid && in_ready;
  assign in_order  = (in_mode == cnt_q);
  assign out_valid = (state_q == HOLD);
  assign err_order = err_order_q;

  // Score datapath. Mode 0 uses the live lambda because lambda_q is only
  // loaded on that same edge. The sum is exact in 49 bits and zero-extended.
  always_comb begin
    lambda_sel = (cnt_q == 4'd0) ? lambda : lambda_q;
    prod       = {16'b0, in_rate} * {32'b0, lambda_sel};
    disto_ext  = {32'b0, in_disto} << DISTO_SHIFT;
    score_new  = {16'b0, prod} + disto_ext;
  end

  // Collection control. Abort wins over everything. In HOLD, inputs are blocked
  // until the set is taken.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lambda_d    = lambda_q;
    score_d     = score_q;
    err_order_d = 1'b0;
    if (abort) begin
      state_d = COLLECT;
      cnt_d   = 4'd0;
    end else if (state_q == HOLD) begin
      if (out_ready) state_d = COLLECT;
    end else if (accept) begin
      if (in_order) begin
        for (int i = 0; i < NUM_MODES; i++)
          if (cnt_q == 4'(i)) score_d[i] = score_new;
        if (cnt_q == 4'd0) lambda_d = lambda;
        if (cnt_q == 4'(NUM_MODES - 1)) begin
          cnt_d   = 4'd0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        err_order_d = 1'b1;
      end
    end
  end

  // State registers. Reset clears everything, including scores.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= COLLECT;
      cnt_q       <= 4'd0;
      lambda_q    <= 16'd0;
      err_order_q <= 1'b0;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lambda_q    <= lambda_d;
      err_order_q <= err_order_d;
      score_q     <= score_d;
    end
  end

  assign score0 = score_q[0];
  assign score1 = score_q[1];
  assign score2 = score_q[2];
  assign score3 = score_q[3];
  assign score4 = score_q[4];
  assign score5 = score_q[5];
  assign score6 = score_q[6];
  assign score7 = score_q[7];
  assign score8 = score_q[8];
  assign score9 = score_q[9];

endmodule
